// File: rtl/vram_rdarb_pkg.sv
// Shared types for the VRAM read-port arbiter: FSM state, owner index, SC width.
package vram_rdarb_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ADDR = 3'b010,
        S_DATA = 3'b100
    } state_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } own_t;

    localparam int unsigned SC_W = 4;

endpackage

// File: rtl/vram_rdarb_pick.sv
// Grant decision for the VRAM read arbiter; with VRAM_RDARB_STARVE_EN defined it
// also owns the M1 starvation counter and honours URGENT.
module vram_rdarb_pick
    import vram_rdarb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic ACLK,
    input  logic ARST,
    input  logic idle,
    input  logic m0_arvalid,
    input  logic m1_arvalid,
    input  logic urgent,
    output logic gnt_vld,
    output own_t gnt_idx
);

    logic contested;

    assign contested = m0_arvalid & m1_arvalid;
    assign gnt_vld   = idle & (m0_arvalid | m1_arvalid);

`ifdef VRAM_RDARB_STARVE_EN
    localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_MAX);
    localparam logic [SC_W-1:0] SC_SAT   = '1;

    logic [SC_W-1:0] sc;
    logic            tripped;

    assign tripped = (sc >= SC_LIMIT);

    always_comb begin
        gnt_idx = OWN_M0;
        if (contested)
            gnt_idx = (tripped && !urgent) ? OWN_M1 : OWN_M0;
        else if (m1_arvalid)
            gnt_idx = OWN_M1;
    end

    // Counts only M0 wins that left M1 waiting; any other grant restarts the count.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            sc <= '0;
        end else if (gnt_vld) begin
            if (gnt_idx == OWN_M1 || !m1_arvalid)
                sc <= '0;
            else if (sc != SC_SAT)
                sc <= sc + SC_W'(1);
        end
    end
`else
    logic unused_cfg;

    assign gnt_idx    = (m1_arvalid && !m0_arvalid) ? OWN_M1 : OWN_M0;
    assign unused_cfg = ^{ACLK, ARST, urgent, contested, (STARVE_MAX != 0)};
`endif

endmodule

// File: rtl/vram_rdarb.sv
// Two-requester arbiter for the VRAM AXI read port (M0 display, M1 draw engine).
// Define VRAM_RDARB_STARVE_EN to build the M1 starvation guard and URGENT handling.
module vram_rdarb
    import vram_rdarb_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              URGENT,

    input  logic [31:0]       M0_ARADDR,
    input  logic              M0_ARVALID,
    output logic              M0_ARREADY,
    output logic [DATA_W-1:0] M0_RDATA,
    output logic              M0_RLAST,
    output logic              M0_RVALID,
    input  logic              M0_RREADY,

    input  logic [31:0]       M1_ARADDR,
    input  logic              M1_ARVALID,
    output logic              M1_ARREADY,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic              M1_RLAST,
    output logic              M1_RVALID,
    input  logic              M1_RREADY,

    output logic [31:0]       S_ARADDR,
    output logic              S_ARVALID,
    input  logic              S_ARREADY,
    input  logic [DATA_W-1:0] S_RDATA,
    input  logic              S_RLAST,
    input  logic              S_RVALID,
    output logic              S_RREADY
);

    state_t      state;
    own_t        own;
    logic [31:0] araddr_q;
    logic        idle;
    logic        in_data;
    logic        gnt_vld;
    own_t        gnt_idx;

    // No grant while reset is held so ARREADY stays low during reset.
    assign idle    = (state == S_IDLE) && !ARST;
    assign in_data = (state == S_DATA);

    vram_rdarb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .idle       (idle),
        .m0_arvalid (M0_ARVALID),
        .m1_arvalid (M1_ARVALID),
        .urgent     (URGENT),
        .gnt_vld    (gnt_vld),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state    <= S_IDLE;
            own      <= OWN_M0;
            araddr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        araddr_q <= (gnt_idx == OWN_M1) ? M1_ARADDR : M0_ARADDR;
                        own      <= gnt_idx;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (S_ARREADY)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (S_RVALID && S_RREADY && S_RLAST)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign M0_ARREADY = gnt_vld && (gnt_idx == OWN_M0);
    assign M1_ARREADY = gnt_vld && (gnt_idx == OWN_M1);

    assign S_ARADDR  = araddr_q;
    assign S_ARVALID = (state == S_ADDR);

    assign M0_RDATA  = S_RDATA;
    assign M1_RDATA  = S_RDATA;
    assign M0_RVALID = in_data && (own == OWN_M0) && S_RVALID;
    assign M1_RVALID = in_data && (own == OWN_M1) && S_RVALID;
    assign M0_RLAST  = in_data && (own == OWN_M0) && S_RLAST;
    assign M1_RLAST  = in_data && (own == OWN_M1) && S_RLAST;
    assign S_RREADY  = in_data && ((own == OWN_M1) ? M1_RREADY : M0_RREADY);

endmodule

// File: tb/tb_vram_rdarb.sv
// Randomised bench for vram_rdarb against a transaction-level arbitration model.
module tb_vram_rdarb;

    localparam int DATA_W     = 64;
    localparam int STARVE_MAX = 4;
`ifdef VRAM_RDARB_STARVE_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              ACLK = 1'b0;
    logic              ARST;
    logic              URGENT;
    logic [31:0]       raddr [2];
    logic              rv [2];
    logic              rr [2];
    logic              m_arready [2];
    logic              m_rvalid [2];
    logic              m_rlast [2];
    logic [DATA_W-1:0] m_rdata [2];
    logic [31:0]       S_ARADDR;
    logic              S_ARVALID;
    logic              s_arready;
    logic [DATA_W-1:0] s_rdata;
    logic              s_rlast;
    logic              s_rvalid;
    logic              S_RREADY;

    always #5 ACLK = ~ACLK;

    vram_rdarb #(
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .URGENT     (URGENT),
        .M0_ARADDR  (raddr[0]),
        .M0_ARVALID (rv[0]),
        .M0_ARREADY (m_arready[0]),
        .M0_RDATA   (m_rdata[0]),
        .M0_RLAST   (m_rlast[0]),
        .M0_RVALID  (m_rvalid[0]),
        .M0_RREADY  (rr[0]),
        .M1_ARADDR  (raddr[1]),
        .M1_ARVALID (rv[1]),
        .M1_ARREADY (m_arready[1]),
        .M1_RDATA   (m_rdata[1]),
        .M1_RLAST   (m_rlast[1]),
        .M1_RVALID  (m_rvalid[1]),
        .M1_RREADY  (rr[1]),
        .S_ARADDR   (S_ARADDR),
        .S_ARVALID  (S_ARVALID),
        .S_ARREADY  (s_arready),
        .S_RDATA    (s_rdata),
        .S_RLAST    (s_rlast),
        .S_RVALID   (s_rvalid),
        .S_RREADY   (S_RREADY)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model: arbiter busy from grant until the cycle after the last beat.
    bit          busy, addr_phase, data_phase, s_hs, post_reset, rst_arm;
    bit          drop [2];
    int          own, beat, len, got_beats, starve, ar_wait;
    logic [31:0] own_addr;
    int          rx_total [2];
    int          gnt_q [$];

    // Stimulus knobs.
    int p_req [2];
    int p_rr, p_srv, ar_fix, urg_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic evaluate();
        int w;
        bit g;
        if (rv[0] && rv[1])
            w = (GUARD && starve >= STARVE_MAX && !URGENT) ? 1 : 0;
        else
            w = rv[1] ? 1 : 0;
        g = !busy && (rv[0] || rv[1]);

        check("m0_arready", m_arready[0], g && w == 0);
        check("m1_arready", m_arready[1], g && w == 1);
        check("s_arvalid", S_ARVALID, addr_phase);
        if (addr_phase)
            check("s_araddr", S_ARADDR, own_addr);
        if (post_reset) begin
            check("s_araddr_rst", S_ARADDR, 0);
            post_reset = 0;
        end
        for (int k = 0; k < 2; k++) begin
            check("m_rvalid", m_rvalid[k], data_phase && own == k && s_rvalid);
            check("m_rlast", m_rlast[k], data_phase && own == k && s_rlast);
        end
        check("s_rready", S_RREADY, data_phase && rr[own]);
        if (data_phase && s_rvalid)
            check("m_rdata", m_rdata[own], s_rdata);

        for (int k = 0; k < 2; k++) begin
            if (m_rvalid[k] && rr[k]) begin
                rx_total[k]++;
                if (data_phase && own == k)
                    got_beats++;
            end
            if (rv[k] && m_arready[k])
                drop[k] = 1;
        end
        if (m_arready[1])
            gnt_q.push_back(1);
        else if (m_arready[0])
            gnt_q.push_back(0);

        s_hs = data_phase && s_rvalid && S_RREADY;
        if (g) begin
            busy       = 1;
            own        = w;
            own_addr   = raddr[w];
            addr_phase = 1;
            ar_wait    = (ar_fix >= 0) ? ar_fix : int'($urandom_range(0, 3));
            if (w == 1 || !rv[1])
                starve = 0;
            else if (starve < 15)
                starve++;
        end else if (addr_phase && s_arready) begin
            addr_phase = 0;
            data_phase = 1;
            beat       = 0;
            len        = 8 - int'(own_addr[2:0]);
            got_beats  = 0;
        end else if (s_hs) begin
            if (beat == len - 1) begin
                check("burst_beats", got_beats, len);
                data_phase = 0;
                busy       = 0;
            end else begin
                beat++;
            end
        end
    endtask

    task automatic drive();
        if (ARST) begin
            ARST = 0; busy = 0; addr_phase = 0; data_phase = 0; starve = 0; s_hs = 0;
            drop[0] = 0; drop[1] = 0;
            rv[0] = 0; rv[1] = 0; rr[0] = 0; rr[1] = 0;
            s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0; URGENT = 0;
            post_reset = 1;
            return;
        end
        URGENT = (urg_mode == 2) ? 1'($urandom_range(0, 1)) : (urg_mode == 1);
        for (int k = 0; k < 2; k++) begin
            if (drop[k])
                rv[k] = 0;
            drop[k] = 0;
            if (!rv[k] && int'($urandom_range(0, 99)) < p_req[k]) begin
                rv[k]    = 1;
                raddr[k] = $urandom;
            end
            rr[k] = (p_rr < 0) ? !rr[k] : (int'($urandom_range(0, 99)) < p_rr);
        end
        if (addr_phase) begin
            if (ar_wait > 0) begin
                s_arready = 0;
                ar_wait--;
            end else begin
                s_arready = 1;
            end
        end else begin
            s_arready = 1'($urandom_range(0, 1));
        end
        if (!data_phase)
            s_rvalid = 0;
        else if (!s_rvalid || s_hs)
            s_rvalid = int'($urandom_range(0, 99)) < p_srv;
        s_rdata = s_rvalid ? {own_addr, 32'(beat)} : DATA_W'($urandom);
        s_rlast = s_rvalid && (beat == len - 1);
        s_hs    = 0;
        if (rst_arm && data_phase && own == 1 && beat == 2 && s_rvalid) begin
            ARST    = 1;
            rst_arm = 0;
        end
    endtask

    task automatic cycle();
        @(negedge ACLK);
        if (!ARST)
            evaluate();
        @(posedge ACLK);
        #1;
        drive();
    endtask

    task automatic drain();
        p_req[0] = 0; p_req[1] = 0; urg_mode = 0;
        for (int i = 0; i < 600 && (busy || rv[0] || rv[1]); i++)
            cycle();
        check("drain", busy || rv[0] || rv[1], 0);
    endtask

    initial begin
        ARST = 1; URGENT = 0; s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            rv[k] = 0; rr[k] = 0; raddr[k] = '0; drop[k] = 0; rx_total[k] = 0; p_req[k] = 0;
        end
        busy = 0; addr_phase = 0; data_phase = 0; s_hs = 0; post_reset = 0; rst_arm = 0;
        own = 0; beat = 0; len = 1; got_beats = 0; starve = 0; ar_wait = 0; own_addr = '0;
        p_rr = 100; p_srv = 100; ar_fix = 0; urg_mode = 0;
        repeat (2) cycle();

        // Single M0 burst of 8 beats at 0x1000_0000.
        gnt_q.delete();
        rv[0] = 1; raddr[0] = 32'h1000_0000;
        repeat (16) cycle();
        check("p1_m0_beats", rx_total[0], 8);
        check("p1_m1_beats", rx_total[1], 0);
        check("p1_grants", gnt_q.size(), 1);

        // Both requesters continuously busy.
        gnt_q.delete();
        p_req[0] = 100; p_req[1] = 100;
        for (int i = 0; i < 600 && gnt_q.size() < 10; i++)
            cycle();
        check("p2_grant_count", gnt_q.size(), 10);
        for (int i = 0; i < 10; i++)
            check("p2_grant_seq", (i < gnt_q.size()) ? gnt_q[i] : 9, (GUARD && i % 5 == 4) ? 1 : 0);

        // Same with URGENT held high.
        urg_mode = 1;
        cycle();
        gnt_q.delete();
        for (int i = 0; i < 600 && gnt_q.size() < 10; i++)
            cycle();
        check("p3_grant_count", gnt_q.size(), 10);
        for (int i = 0; i < 10; i++)
            check("p3_grant_seq", (i < gnt_q.size()) ? gnt_q[i] : 9, 0);
        drain();

        // Address back-pressure and toggling RREADY.
        ar_fix = 5; p_rr = -1; p_srv = 100;
        p_req[0] = 100;
        repeat (80) cycle();
        drain();

        // Reset during beat 3 of an M1 burst, then a fresh M0 request.
        ar_fix = 0; p_rr = 100; p_srv = 100;
        rv[1] = 1; raddr[1] = 32'h2000_0000;
        rst_arm = 1;
        for (int i = 0; i < 40 && !post_reset; i++)
            cycle();
        check("rst_taken", post_reset, 1);
        cycle();
        gnt_q.delete();
        rv[0] = 1; raddr[0] = $urandom;
        for (int i = 0; i < 10 && gnt_q.size() == 0; i++)
            cycle();
        check("post_rst_grant", (gnt_q.size() > 0) ? gnt_q[0] : 9, 0);
        drain();

        // Random traffic with random URGENT and back-pressure.
        ar_fix = -1; p_rr = 70; p_srv = 70; urg_mode = 2;
        p_req[0] = 60; p_req[1] = 30;
        repeat (1500) cycle();
        p_req[0] = 20; p_req[1] = 80;
        repeat (1500) cycle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_rdarb.md
# vram_rdarb

Two-requester arbiter for the single AXI read port of the VRAM. Sits between the display VRAM reader (requester 0, M0) and the drawing/readback engine (requester 1, M1) on one side, and the VRAM AXI slave on the other. Grants one burst at a time, with display priority and an urgent override. An optional guard prevents M1 from being starved indefinitely.

## Interface
- DATA_W, 64: R-channel data width.
- STARVE_MAX, 4: consecutive M0 grants with M1 pending before M1 is forced a grant (guard builds only); range 1..15.
- ACLK  in  1  clock.
- ARST  in  1  reset, synchronous, active-high.
- URGENT  in  1  display buffer below low watermark; M0 wins every contested arbitration.
- M0_ARADDR / M1_ARADDR  in  32  requester burst address.
- M0_ARVALID / M1_ARVALID  in  1  requester address valid.
- M0_ARREADY / M1_ARREADY  out  1  address accepted by the arbiter.
- M0_RDATA / M1_RDATA  out  DATA_W  read data, broadcast from S_RDATA.
- M0_RLAST / M1_RLAST, M0_RVALID / M1_RVALID  out  1  routed R-channel qualifiers.
- M0_RREADY / M1_RREADY  in  1  requester data ready.
- S_ARADDR  out  32  registered slave address.
- S_ARVALID  out  1  slave address valid.
- S_ARREADY  in  1  slave address ready.
- S_RDATA  in  DATA_W  slave read data.
- S_RLAST, S_RVALID  in  1  slave R-channel qualifiers.
- S_RREADY  out  1  slave data ready.

## Operation
- States: S_IDLE, S_ADDR, S_DATA. One outstanding burst only. Owner register OWN (0 = M0, 1 = M1).
- S_IDLE, grant decision:
  - Only one ARVALID set: grant that requester.
  - Both set: grant M1 if the guard has tripped and URGENT is 0; otherwise grant M0.
- On a grant:
  - The granted requester's Mx_ARREADY is asserted combinationally in that same cycle.
  - S_ARADDR <= Mx_ARADDR; OWN <= x; next state S_ADDR.
- S_ADDR: S_ARVALID = 1. On S_ARREADY, go to S_DATA.
- S_DATA, R-channel routing:
  - M[OWN]_RVALID = S_RVALID; M[OWN]_RLAST = S_RLAST; S_RREADY = M[OWN]_RREADY.
  - The non-owner sees RVALID = 0 and RLAST = 0.
  - On S_RVALID & S_RREADY & S_RLAST, go to S_IDLE.
- Outputs outside their state: S_ARVALID = 0 outside S_ADDR. S_RREADY and all Mx_RVALID = 0 outside S_DATA.
- Starvation counter SC, 4 bits, guard builds only:
  - Increments on each M0 grant made while M1_ARVALID = 1.
  - Clears on any M1 grant.
  - Clears on any grant made while M1_ARVALID = 0.
  - Saturates at 15.
  - Guard trips when SC >= STARVE_MAX.
- Requesters must hold ARVALID and ARADDR until their ARREADY, per the AXI rule. Withdrawing ARVALID early is not supported.
- Reset (any state, including mid-burst):
  - State -> S_IDLE; OWN = 0; SC = 0; S_ARADDR = 0.
  - All VALID/READY/LAST outputs = 0.
  - Remaining beats of an abandoned burst are not drained; the whole system is reset together.

## Timing
- Grant to S_ARVALID: 1 cycle (the Mx_ARREADY cycle is followed by S_ARVALID = 1).
- S_ARVALID is held until S_ARREADY. S_ARADDR is stable for the whole of S_ADDR.
- R path is combinational, zero added latency. Throughput is 1 beat/cycle when both sides are ready.
- The last beat at cycle t returns the FSM to S_IDLE at t+1. The earliest next grant is at t+1, so S_ARVALID can reassert no earlier than t+2.
- URGENT is sampled only in the S_IDLE grant cycle. It never preempts a burst in progress.

## Configuration
- VRAM_RDARB_STARVE_EN defined: the starvation guard (SC, STARVE_MAX) is built as described above.
- Not defined: pure fixed priority, M0 always wins a contested grant, and URGENT has no effect. SC is not instantiated and STARVE_MAX is ignored.

## Structure
- Shared package holds:
  - the state encoding (one-hot, 3 bits);
  - the owner encoding;
  - the SC width constant.
- The grant-decision logic and SC form one natural sub-module, vram_rdarb_pick.
  - Inputs: both ARVALIDs, URGENT, an "in S_IDLE" qualifier.
  - Outputs: a grant-valid strobe and the granted index.
  - Owns SC.

## Test plan
- Only M0 requests, address 0x1000_0000, 8-beat burst:
  - M0_ARREADY pulses for 1 cycle; S_ARVALID rises the next cycle with S_ARADDR = 0x1000_0000.
  - M0 receives all 8 beats; M1_RVALID stays 0.
- Both request continuously, URGENT = 0, guard built, STARVE_MAX = 4:
  - Grant sequence is M0, M0, M0, M0, M1, M0, M0, M0, M0, M1.
- Same stimulus with URGENT = 1: all grants go to M0. Repeat without the macro: all grants go to M0.
- Back-pressure: S_ARREADY held low 5 cycles, then M0_RREADY toggles each cycle:
  - S_ARVALID is held for 5 cycles with S_ARADDR stable.
  - S_RREADY mirrors M0_RREADY; no beat is lost or duplicated.
- Reset asserted on beat 3 of an M1 burst:
  - The next cycle shows S_IDLE with all VALID/READY outputs = 0 and S_ARADDR = 0.
  - A fresh M0 request after reset is granted normally.
- Last beat coincides with a new M1 ARVALID:
  - M1_ARREADY is asserted the cycle after the last beat; S_ARVALID follows one cycle later.
